dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises the two lane memory requests of a dual-issue
// bundle onto one shared memory port. Lane 0 (older) always goes first.
//
// Ports:
//   clk, reset (async, active-low)
//   lane 0/1 : mem_readN, mem_writeN, addrN[AW], wdataN[DW]
//   pipeline : stall_mem, resp_valid, rdata0[DW], rdata1[DW]
//   memory   : mem_req, mem_we, mem_addr[AW], mem_wdata[DW], mem_ready, mem_rdata[DW]
//
// Optional feature: define DMEM_ST_LD_FWD_EN to forward lane-0 store data
// to a lane-1 load of the same address without a second memory access.
module dmem_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read0,
  input  logic          mem_write0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          mem_read1,
  input  logic          mem_write1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          stall_mem,
  output logic          resp_valid,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ0 = 2'd1,
    ST_REQ1 = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_resp_valid;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic w_active0;
  logic w_active1;
  logic w_fwd;

  assign w_active0 = mem_read0 | mem_write0;
  assign w_active1 = mem_read1 | mem_write1;

  // Lane 1 is a load (write has precedence) of the address lane 0 stores to
`ifdef DMEM_ST_LD_FWD_EN
  assign w_fwd = mem_write0 & w_active1 & ~mem_write1 & (addr0 == addr1);
`else
  assign w_fwd = 1'b0;
`endif

  // Sequencer: state plus registered request/response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          if (w_active0) begin
            r_state   <= ST_REQ0;
            r_mem_req <= 1'b1;
            r_mem_we  <= mem_write0;
          end else if (w_active1) begin
            r_state   <= ST_REQ1;
            r_mem_req <= 1'b1;
            r_mem_we  <= mem_write1;
          end
        end
        ST_REQ0: begin
          if (mem_ready) begin
            if (!mem_write0) r_rdata0 <= mem_rdata;
            if (w_active1 && !w_fwd) begin
              r_state  <= ST_REQ1;
              r_mem_we <= mem_write1;
            end else begin
              r_state      <= ST_DONE;
              r_mem_req    <= 1'b0;
              r_mem_we     <= 1'b0;
              r_resp_valid <= 1'b1;
              if (w_fwd) r_rdata1 <= wdata0;
            end
          end
        end
        ST_REQ1: begin
          if (mem_ready) begin
            if (!mem_write1) r_rdata1 <= mem_rdata;
            r_state      <= ST_DONE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_req    <= 1'b0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Request fields follow the lane being serviced; inputs are held stable by the stall
  assign mem_addr  = (r_state == ST_REQ1) ? addr1  : addr0;
  assign mem_wdata = (r_state == ST_REQ1) ? wdata1 : wdata0;

  // In IDLE the stall must rise in the same cycle the bundle arrives
  always_comb begin
    stall_mem = 1'b0;
    case (r_state)
      ST_IDLE: stall_mem = w_active0 | w_active1;
      ST_REQ0: stall_mem = 1'b1;
      ST_REQ1: stall_mem = 1'b1;
      default: stall_mem = 1'b0;
    endcase
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign resp_valid = r_resp_valid;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small memory model.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        mem_read0, mem_write0, mem_read1, mem_write1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        stall_mem, resp_valid, mem_req, mem_we, mem_ready;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  // Memory model and access log
  logic [31:0] mem [0:255];
  logic [31:0] acc_addr [0:63];
  logic        acc_we [0:63];
  int          n_acc = 0;
  int          req_age;
  int          ready_dly;
  logic        blk_en;
  logic [31:0] blk_addr;

  dmem_port_arbiter #(.DW(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read0(mem_read0), .mem_write0(mem_write0), .addr0(addr0), .wdata0(wdata0),
    .mem_read1(mem_read1), .mem_write1(mem_write1), .addr1(addr1), .wdata1(wdata1),
    .stall_mem(stall_mem), .resp_valid(resp_valid), .rdata0(rdata0), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (req_age >= ready_dly) && !(blk_en && (mem_addr == blk_addr));

  always @(posedge clk or negedge reset) begin
    if (!reset) req_age <= 0;
    else if (mem_req && !mem_ready) req_age <= req_age + 1;
    else req_age <= 0;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      acc_addr[n_acc % 64] <= mem_addr;
      acc_we[n_acc % 64]   <= mem_we;
      n_acc                <= n_acc + 1;
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic clear_lanes();
    mem_read0 = 1'b0; mem_write0 = 1'b0; addr0 = '0; wdata0 = '0;
    mem_read1 = 1'b0; mem_write1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one bundle from IDLE until resp_valid, then lets the pipeline advance.
  task automatic run_bundle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            output int lat, output int stl, output int nacc, output int reqc,
                            output int achg, output logic done_req, output logic tmo);
    int base;
    logic [31:0] pa;
    logic preq;
    base = n_acc; lat = 0; stl = 0; reqc = 0; achg = 0; done_req = 1'b0; tmo = 1'b1;
    preq = 1'b0; pa = '0;
    mem_read0 = r0; mem_write0 = w0; addr0 = a0; wdata0 = d0;
    mem_read1 = r1; mem_write1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    for (int c = 1; c <= 30; c++) begin
      if (stall_mem) stl++;
      if (mem_req) begin
        reqc++;
        if (preq && (mem_addr !== pa)) achg++;
      end
      preq = mem_req; pa = mem_addr;
      if (resp_valid) begin
        lat = c; done_req = mem_req | mem_we | stall_mem; tmo = 1'b0;
        break;
      end
      step();
    end
    step();
    clear_lanes();
    #1;
    nacc = n_acc - base;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_lanes();
    repeat (3) step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_mem); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({stall_mem, mem_req, resp_valid} !== 3'b000) begin
        errors++; $display("FAIL idle_cycle%0d got stall/req/resp=%b exp=000", i, {stall_mem, mem_req, resp_valid});
      end
      step();
    end
  endtask

  task automatic test_single_load();
    int lat, stl, nacc, reqc, achg, b; logic dr, tmo;
    b = n_acc;
    run_bundle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, lat, stl, nacc, reqc, achg, dr, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout got=1 exp=0"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", lat); end
    checks++; if (stl != 2) begin errors++; $display("FAIL single_stall got=%0d exp=2", stl); end
    checks++; if (nacc != 1) begin errors++; $display("FAIL single_accesses got=%0d exp=1", nacc); end
    checks++; if (acc_addr[b % 64] !== 32'h100 || acc_we[b % 64] !== 1'b0) begin
      errors++; $display("FAIL single_access got=%h we=%0b exp=00000100 we=0", acc_addr[b % 64], acc_we[b % 64]); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata0 got=%h exp=deadbeef", rdata0); end
    checks++; if (dr !== 1'b0) begin errors++; $display("FAIL single_done_outputs got=%0b exp=0", dr); end
  endtask

  task automatic test_store_load_pair();
    int lat, stl, nacc, reqc, achg, b; logic dr, tmo;
    b = n_acc;
    run_bundle(1'b0, 1'b1, 32'h20, 32'h11, 1'b1, 1'b0, 32'h24, 32'h0, lat, stl, nacc, reqc, achg, dr, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL pair_timeout got=1 exp=0"); end
    checks++; if (lat != 4) begin errors++; $display("FAIL pair_latency got=%0d exp=4", lat); end
    checks++; if (stl != 3) begin errors++; $display("FAIL pair_stall got=%0d exp=3", stl); end
    checks++; if (nacc != 2) begin errors++; $display("FAIL pair_accesses got=%0d exp=2", nacc); end
    checks++; if (acc_addr[b % 64] !== 32'h20 || acc_we[b % 64] !== 1'b1) begin
      errors++; $display("FAIL pair_first got=%h we=%0b exp=00000020 we=1", acc_addr[b % 64], acc_we[b % 64]); end
    checks++; if (acc_addr[(b + 1) % 64] !== 32'h24 || acc_we[(b + 1) % 64] !== 1'b0) begin
      errors++; $display("FAIL pair_second got=%h we=%0b exp=00000024 we=0", acc_addr[(b + 1) % 64], acc_we[(b + 1) % 64]); end
    checks++; if (rdata1 !== 32'h55) begin errors++; $display("FAIL pair_rdata1 got=%h exp=00000055", rdata1); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL pair_rdata0_kept got=%h exp=deadbeef", rdata0); end
    checks++; if (mem[8] !== 32'h11) begin errors++; $display("FAIL pair_mem_store got=%h exp=00000011", mem[8]); end
  endtask

  task automatic test_delayed_ready();
    int lat, stl, nacc, reqc, achg, b; logic dr, tmo;
    b = n_acc;
    ready_dly = 3;
    run_bundle(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, lat, stl, nacc, reqc, achg, dr, tmo);
    ready_dly = 0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL delay_timeout got=1 exp=0"); end
    checks++; if (reqc != 4) begin errors++; $display("FAIL delay_req_cycles got=%0d exp=4", reqc); end
    checks++; if (achg != 0) begin errors++; $display("FAIL delay_addr_changes got=%0d exp=0", achg); end
    checks++; if (lat != 6) begin errors++; $display("FAIL delay_latency got=%0d exp=6", lat); end
    checks++; if (nacc != 1 || acc_addr[b % 64] !== 32'h24) begin
      errors++; $display("FAIL delay_access got=%0d@%h exp=1@00000024", nacc, acc_addr[b % 64]); end
  endtask

  task automatic test_fwd_case();
    int lat, stl, nacc, reqc, achg; logic dr, tmo;
    int exp_acc, exp_lat;
`ifdef DMEM_ST_LD_FWD_EN
    exp_acc = 1; exp_lat = 3;
`else
    exp_acc = 2; exp_lat = 4;
`endif
    run_bundle(1'b0, 1'b1, 32'h40, 32'hA5, 1'b1, 1'b0, 32'h40, 32'h0, lat, stl, nacc, reqc, achg, dr, tmo);
    checks++; if (nacc != exp_acc) begin errors++; $display("FAIL fwd_accesses got=%0d exp=%0d", nacc, exp_acc); end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL fwd_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (rdata1 !== 32'hA5) begin errors++; $display("FAIL fwd_rdata1 got=%h exp=000000a5", rdata1); end
    checks++; if (mem[16] !== 32'hA5) begin errors++; $display("FAIL fwd_mem got=%h exp=000000a5", mem[16]); end
  endtask

  task automatic test_same_addr_stores();
    int lat, stl, nacc, reqc, achg, b; logic dr, tmo;
    logic [31:0] r0_before, r1_before;
    b = n_acc; r0_before = rdata0; r1_before = rdata1;
    // Lane 1 has both read and write set: the write must win
    run_bundle(1'b0, 1'b1, 32'h60, 32'h1, 1'b1, 1'b1, 32'h60, 32'h2, lat, stl, nacc, reqc, achg, dr, tmo);
    checks++; if (nacc != 2) begin errors++; $display("FAIL st_st_accesses got=%0d exp=2", nacc); end
    checks++; if (acc_we[(b + 1) % 64] !== 1'b1) begin errors++; $display("FAIL st_st_write_prio got=%0b exp=1", acc_we[(b + 1) % 64]); end
    checks++; if (mem[24] !== 32'h2) begin errors++; $display("FAIL st_st_final got=%h exp=00000002", mem[24]); end
    checks++; if (rdata0 !== r0_before || rdata1 !== r1_before) begin
      errors++; $display("FAIL st_st_rdata_kept got=%h/%h exp=%h/%h", rdata0, rdata1, r0_before, r1_before); end
  endtask

  task automatic test_reset_mid_req1();
    int lat, stl, nacc, reqc, achg; logic dr, tmo;
    blk_en = 1'b1; blk_addr = 32'h24;
    mem_read0 = 1'b1; addr0 = 32'h100; mem_read1 = 1'b1; addr1 = 32'h24;
    step(); step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h24) begin
      errors++; $display("FAIL rst_in_req1 got req=%0b addr=%h exp req=1 addr=00000024", mem_req, mem_addr); end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop got=%0b exp=0", mem_req); end
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata_clear got=%h/%h exp=0/0", rdata0, rdata1); end
    clear_lanes();
    blk_en = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL rst_no_resp cycle%0d got resp=%0b req=%0b exp 0/0", i, resp_valid, mem_req); end
    end
    run_bundle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, lat, stl, nacc, reqc, achg, dr, tmo);
    checks++; if (lat != 3 || rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rst_recover got lat=%0d rdata0=%h exp lat=3 rdata0=deadbeef", lat, rdata0); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = 32'hDEADBEEF;
    mem[9]  = 32'h55;
    ready_dly = 0; blk_en = 1'b0; blk_addr = '0;
    test_reset();
    test_idle();
    test_single_load();
    test_store_load_pair();
    test_delayed_ready();
    test_fwd_case();
    test_same_addr_stores();
    test_reset_mid_req1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
